// File: rtl/exc_pkg.sv
// Shared definitions for the memory-stage exception controller: cause codes,
// exc_flags bit positions, handler vector, FSM states and the CP0 bus layout.
package exc_pkg;

  localparam logic [31:0] EXC_VECTOR = 32'hBFC0_0380;

  // Bit positions inside exc_flags
  localparam int FLAG_ADEL_IF = 0;
  localparam int FLAG_RI      = 1;
  localparam int FLAG_OV      = 2;
  localparam int FLAG_SYS     = 3;
  localparam int FLAG_BP      = 4;
  localparam int FLAG_ADEL_LD = 5;
  localparam int FLAG_ADES    = 6;
  localparam int FLAG_ERET    = 7;

  typedef enum logic [3:0] {
    EXC_NONE = 4'h0,
    EXC_INT  = 4'h1,
    EXC_ADEL = 4'h4,
    EXC_ADES = 4'h5,
    EXC_SYS  = 4'h8,
    EXC_BP   = 4'h9,
    EXC_RI   = 4'hA,
    EXC_OV   = 4'hC,
    EXC_ERET = 4'hE
  } exc_code_e;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_FLUSH    = 2'd1,
    ST_REDIRECT = 2'd2
  } exc_state_e;

  // 69-bit record handed to CP0; field order fixes the packed layout.
  typedef struct packed {
    logic [31:0] badaddr;
    logic        delayslot;
    logic [31:0] pc;
    exc_code_e   code;
  } cp0_bus_t;

  // Interrupt request: any enabled pending line, global IE set, not in EXL.
  function automatic logic irq_pending(input logic [31:0] status,
                                       input logic [31:0] cause);
    return (|(cause[15:8] & status[15:8])) & status[0] & ~status[1];
  endfunction

endpackage

// File: rtl/exc_prio_enc.sv
// Combinational priority selection of the memory-stage event and its
// faulting address. Pure logic; the FSM decides whether the result is used.
module exc_prio_enc
  import exc_pkg::*;
(
  input  logic        valid,
  input  logic        irq,
  input  logic [7:0]  flags,
  input  logic [31:0] pc,
  input  logic [31:0] badaddr_in,
  output logic        hit,
  output logic        is_eret,
  output logic [3:0]  code,
  output logic [31:0] badaddr
);

  exc_code_e code_s;

  // NOTE: every output gets a default first so no path through the
  // if/else chain leaves a value unassigned and infers a latch.
  always_comb begin
    code_s  = EXC_NONE;
    badaddr = '0;
    if (valid) begin
      if (irq) begin
        code_s = EXC_INT;
      end else if (flags[FLAG_ADEL_IF]) begin
        code_s  = EXC_ADEL;
        badaddr = pc;
      end else if (flags[FLAG_RI]) begin
        code_s = EXC_RI;
      end else if (flags[FLAG_OV]) begin
        code_s = EXC_OV;
      end else if (flags[FLAG_SYS]) begin
        code_s = EXC_SYS;
      end else if (flags[FLAG_BP]) begin
        code_s = EXC_BP;
      end else if (flags[FLAG_ADEL_LD]) begin
        code_s  = EXC_ADEL;
        badaddr = badaddr_in;
      end else if (flags[FLAG_ADES]) begin
        code_s  = EXC_ADES;
        badaddr = badaddr_in;
      end else if (flags[FLAG_ERET]) begin
        code_s = EXC_ERET;
      end
    end
  end

  assign code    = code_s;
  assign hit     = (code_s != EXC_NONE);
  assign is_eret = (code_s == EXC_ERET);

endmodule

// File: rtl/except_ctrl.sv
// Memory-stage exception controller: reports the selected event to CP0,
// then flushes the pipeline and redirects fetch to the handler or EPC.
module except_ctrl
  import exc_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        m_valid,
  input  logic [31:0] m_pc,
  input  logic        m_delayslot,
  input  logic [31:0] m_badaddr,
  input  logic [7:0]  exc_flags,
  input  logic [31:0] cp0_status,
  input  logic [31:0] cp0_cause,
  input  logic [31:0] cp0_epc,
  input  logic        fetch_ready,
  output logic [68:0] m_cp0_bus,
  output logic        flush,
  output logic        stall,
  output logic        redirect_valid,
  output logic [31:0] redirect_pc
);

  exc_state_e  state, next_state;
  logic [31:0] target_q;
  logic        eret_q;

  logic        sel_hit;
  logic        sel_eret;
  logic [3:0]  sel_code;
  logic [31:0] sel_badaddr;
  logic        take;
  cp0_bus_t    bus_s;

  exc_prio_enc u_prio (
    .valid      (m_valid),
    .irq        (irq_pending(cp0_status, cp0_cause)),
    .flags      (exc_flags),
    .pc         (m_pc),
    .badaddr_in (m_badaddr),
    .hit        (sel_hit),
    .is_eret    (sel_eret),
    .code       (sel_code),
    .badaddr    (sel_badaddr)
  );

  // Events are only accepted from IDLE; anything arriving mid-sequence is dropped.
  assign take = (state == ST_IDLE) && !rst && sel_hit;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      target_q <= '0;
      eret_q   <= 1'b0;
    end else begin
      state <= next_state;
      if (take) begin
        eret_q   <= sel_eret;
        target_q <= sel_eret ? '0 : EXC_VECTOR;
      end else if (state == ST_FLUSH && eret_q) begin
        // EPC is read one cycle late so an MTC0 retiring alongside is seen.
        target_q <= cp0_epc;
      end
    end
  end

  always_comb begin
    next_state     = state;
    flush          = 1'b0;
    stall          = 1'b0;
    redirect_valid = 1'b0;
    case (state)
      ST_IDLE: begin
        if (take) next_state = ST_FLUSH;
      end
      ST_FLUSH: begin
        flush      = 1'b1;
        stall      = 1'b1;
        next_state = ST_REDIRECT;
      end
      ST_REDIRECT: begin
        stall          = 1'b1;
        redirect_valid = 1'b1;
        if (fetch_ready) next_state = ST_IDLE;
      end
      default: next_state = ST_IDLE;
    endcase
    if (rst) begin
      next_state     = ST_IDLE;
      flush          = 1'b0;
      stall          = 1'b0;
      redirect_valid = 1'b0;
    end
  end

  assign redirect_pc = redirect_valid ? target_q : '0;

  always_comb begin
    bus_s = '0;
    if (take) begin
      bus_s.badaddr   = sel_badaddr;
      bus_s.delayslot = m_delayslot;
      bus_s.pc        = m_pc;
      bus_s.code      = exc_code_e'(sel_code);
    end
  end

  assign m_cp0_bus = bus_s;

endmodule

// File: tb/tb_except_ctrl.sv
// Self-checking bench for except_ctrl: directed scenarios plus randomized
// events compared against a priority-table model of the exception rules.
module tb_except_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        m_valid;
  logic [31:0] m_pc;
  logic        m_delayslot;
  logic [31:0] m_badaddr;
  logic [7:0]  exc_flags;
  logic [31:0] cp0_status;
  logic [31:0] cp0_cause;
  logic [31:0] cp0_epc;
  logic        fetch_ready;
  logic [68:0] m_cp0_bus;
  logic        flush;
  logic        stall;
  logic        redirect_valid;
  logic [31:0] redirect_pc;

  int n_checks = 0;
  int n_fail   = 0;

  // Cause code for each exc_flags bit; bit order is also the priority order.
  logic [3:0] flag_code [8] = '{4'h4, 4'hA, 4'hC, 4'h8, 4'h9, 4'h4, 4'h5, 4'hE};

  except_ctrl dut (
    .clk            (clk),
    .rst            (rst),
    .m_valid        (m_valid),
    .m_pc           (m_pc),
    .m_delayslot    (m_delayslot),
    .m_badaddr      (m_badaddr),
    .exc_flags      (exc_flags),
    .cp0_status     (cp0_status),
    .cp0_cause      (cp0_cause),
    .cp0_epc        (cp0_epc),
    .fetch_ready    (fetch_ready),
    .m_cp0_bus      (m_cp0_bus),
    .flush          (flush),
    .stall          (stall),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc)
  );

  always #5 clk = ~clk;

  function automatic logic [68:0] model_bus(input logic valid, input logic [7:0] flags,
                                            input logic [31:0] status, input logic [31:0] cause,
                                            input logic [31:0] pc, input logic [31:0] baddr,
                                            input logic ds);
    logic [3:0]  info;
    logic [31:0] ba;
    info = 4'h0;
    ba   = 32'h0;
    if (!valid) return 69'h0;
    if ((cause[15:8] & status[15:8]) != 8'h0 && status[0] == 1'b1 && status[1] == 1'b0) begin
      info = 4'h1;
    end else begin
      for (int i = 0; i < 8; i++) begin
        if (flags[i]) begin
          info = flag_code[i];
          if (i == 0) ba = pc;
          else if (i == 5 || i == 6) ba = baddr;
          break;
        end
      end
    end
    if (info == 4'h0) return 69'h0;
    return {ba, ds, pc, info};
  endfunction

  task automatic idle_inputs();
    m_valid     = 1'b0;
    exc_flags   = 8'h0;
    fetch_ready = 1'b0;
  endtask

  task automatic check_ctrl(input string name, input logic e_flush, input logic e_stall,
                            input logic e_rv, input logic [31:0] e_pc);
    n_checks++;
    if ({flush, stall, redirect_valid, redirect_pc} !== {e_flush, e_stall, e_rv, e_pc}) begin
      n_fail++;
      $display("FAIL %s: flush/stall/rv/pc got %b/%b/%b/%h want %b/%b/%b/%h", name,
               flush, stall, redirect_valid, redirect_pc, e_flush, e_stall, e_rv, e_pc);
    end
  endtask

  // One full event sequence starting from IDLE. epc_late is what CP0 EPC
  // holds during the FLUSH cycle; ready_wait is the number of REDIRECT
  // cycles with fetch_ready low before it is raised.
  task automatic run_event(input string name, input logic valid, input logic [7:0] flags,
                           input logic [31:0] status, input logic [31:0] cause,
                           input logic [31:0] pc, input logic [31:0] baddr, input logic ds,
                           input logic [31:0] epc_early, input logic [31:0] epc_late,
                           input int ready_wait);
    logic [68:0] exp_bus;
    logic [31:0] exp_pc;
    int          rv_cycles;
    @(posedge clk); #1;
    m_valid = valid; exc_flags = flags; cp0_status = status; cp0_cause = cause;
    m_pc = pc; m_badaddr = baddr; m_delayslot = ds; cp0_epc = epc_early; fetch_ready = 1'b0;
    #1;
    exp_bus = model_bus(valid, flags, status, cause, pc, baddr, ds);
    n_checks++;
    if (m_cp0_bus !== exp_bus) begin
      n_fail++;
      $display("FAIL %s bus: got %h want %h", name, m_cp0_bus, exp_bus);
    end
    check_ctrl({name, " detect"}, 1'b0, 1'b0, 1'b0, 32'h0);
    @(posedge clk); #1;
    idle_inputs();
    cp0_epc = epc_late;
    #1;
    if (exp_bus[3:0] == 4'h0) begin
      check_ctrl({name, " no-event"}, 1'b0, 1'b0, 1'b0, 32'h0);
      return;
    end
    check_ctrl({name, " flush"}, 1'b1, 1'b1, 1'b0, 32'h0);
    n_checks++;
    if (m_cp0_bus !== 69'h0) begin
      n_fail++;
      $display("FAIL %s flush-bus: got %h want 0", name, m_cp0_bus);
    end
    exp_pc    = (exp_bus[3:0] == 4'hE) ? epc_late : 32'hBFC0_0380;
    rv_cycles = 0;
    for (int i = 0; i <= ready_wait; i++) begin
      @(posedge clk); #1;
      fetch_ready = (i == ready_wait);
      #1;
      if (redirect_valid === 1'b1) rv_cycles++;
      check_ctrl({name, " redirect"}, 1'b0, 1'b1, 1'b1, exp_pc);
    end
    @(posedge clk); #1;
    fetch_ready = 1'b0;
    #1;
    check_ctrl({name, " back-idle"}, 1'b0, 1'b0, 1'b0, 32'h0);
    n_checks++;
    if (rv_cycles != ready_wait + 1) begin
      n_fail++;
      $display("FAIL %s rv-cycles: got %0d want %0d", name, rv_cycles, ready_wait + 1);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle_inputs();
    m_pc = 32'h0; m_badaddr = 32'h0; m_delayslot = 1'b0;
    cp0_status = 32'h0; cp0_cause = 32'h0; cp0_epc = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    m_valid = 1'b1; exc_flags = 8'h08;
    #1;
    check_ctrl("reset ctrl", 1'b0, 1'b0, 1'b0, 32'h0);
    n_checks++;
    if (m_cp0_bus !== 69'h0) begin
      n_fail++;
      $display("FAIL reset bus: got %h want 0", m_cp0_bus);
    end
    @(posedge clk); #1;
    idle_inputs();
    rst = 1'b0;
  endtask

  task automatic test_directed();
    run_event("syscall", 1'b1, 8'h08, 32'h0, 32'h0, 32'h8000_1000, 32'h0, 1'b0,
              32'h0, 32'h0, 0);
    run_event("ov-over-adel-ld", 1'b1, 8'h24, 32'h0, 32'h0, 32'h8000_0100,
              32'h8000_0003, 1'b1, 32'h0, 32'h0, 1);
    run_event("int-wins", 1'b1, 8'h08, 32'h0000_0401, 32'h0000_0400, 32'h8000_0200,
              32'h0, 1'b0, 32'h0, 32'h0, 0);
    run_event("adel-fetch", 1'b1, 8'h81, 32'h0, 32'h0, 32'h8000_0302, 32'h1234_5678,
              1'b0, 32'h0, 32'h0, 0);
    run_event("eret", 1'b1, 8'h80, 32'h0, 32'h0, 32'h8000_0400, 32'h0, 1'b0,
              32'h1111_0000, 32'h8000_2000, 3);
    run_event("int-exl-masked", 1'b1, 8'h00, 32'h0000_0403, 32'h0000_0400,
              32'h8000_0500, 32'h0, 1'b0, 32'h0, 32'h0, 0);
    run_event("invalid", 1'b0, 8'hFF, 32'h0000_0401, 32'h0000_0400, 32'h8000_0600,
              32'h0, 1'b0, 32'h0, 32'h0, 0);
  endtask

  task automatic test_random();
    logic [7:0]  flags;
    logic [31:0] status;
    logic [31:0] cause;
    for (int n = 0; n < 40; n++) begin
      flags  = ($urandom_range(0, 1) == 0) ? 8'(1 << $urandom_range(0, 7)) : 8'($urandom);
      status = {16'h0, 8'($urandom), 6'h0, 2'($urandom)};
      cause  = ($urandom_range(0, 2) == 0) ? {16'h0, 8'($urandom), 8'h0} : 32'h0;
      run_event("random", ($urandom_range(0, 3) != 0), flags, status, cause, $urandom,
                $urandom, 1'($urandom), $urandom, $urandom, $urandom_range(0, 2));
    end
  endtask

  task automatic test_ignore_in_redirect();
    @(posedge clk); #1;
    cp0_status = 32'h0; cp0_cause = 32'h0;
    m_valid = 1'b1; exc_flags = 8'h02; m_pc = 32'h8000_0700;
    @(posedge clk); #1;
    idle_inputs();
    @(posedge clk); #1;
    m_valid = 1'b1; exc_flags = 8'h10; m_pc = 32'h8000_0704;
    #1;
    n_checks++;
    if (m_cp0_bus !== 69'h0) begin
      n_fail++;
      $display("FAIL break-in-redirect bus: got %h want 0", m_cp0_bus);
    end
    fetch_ready = 1'b1;
    @(posedge clk); #1;
    idle_inputs();
    @(posedge clk); #1;
    check_ctrl("break-in-redirect dropped", 1'b0, 1'b0, 1'b0, 32'h0);
  endtask

  task automatic test_reset_mid();
    @(posedge clk); #1;
    m_valid = 1'b1; exc_flags = 8'h08; m_pc = 32'h8000_0800;
    @(posedge clk); #1;
    idle_inputs();
    #1;
    check_ctrl("mid-rst flush", 1'b1, 1'b1, 1'b0, 32'h0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    check_ctrl("mid-rst after", 1'b0, 1'b0, 1'b0, 32'h0);
    n_checks++;
    if (m_cp0_bus !== 69'h0) begin
      n_fail++;
      $display("FAIL mid-rst bus: got %h want 0", m_cp0_bus);
    end
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check_ctrl("mid-rst no redirect", 1'b0, 1'b0, 1'b0, 32'h0);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_ignore_in_redirect();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
